// File: rtl/commit_pkg.sv
// commit_pkg: shared commit entry type, checker states and counter width
package commit_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } commit_t;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} chk_state_t;
endpackage

// File: rtl/commit_fifo.sv
// commit_fifo: synchronous FIFO with extra pointer MSB telling full from empty
module commit_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 37
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Push,
    input  logic         Pop,
    input  logic [W-1:0] PushData,
    output logic         Full,
    output logic         Empty,
    output logic [W-1:0] Head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wrPtr, rdPtr;
    assign Empty = wrPtr == rdPtr;
    assign Full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign Head = mem[rdPtr[AW-1:0]];
    always_ff @(posedge Clock) begin
        if (Push) mem[wrPtr[AW-1:0]] <= PushData;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (Push) wrPtr <= wrPtr + 1'b1;
            if (Pop) rdPtr <= rdPtr + 1'b1;
        end
    end
endmodule

// File: rtl/commit_checker.sv
// commit_checker: in-order scoreboard comparing expected and actual commit streams
module commit_checker #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH = 8,
    parameter int MAX_LAG = 64,
    parameter int IGNORE_ZERO = 1
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          ExpValid,
    input  logic [ADDR_W-1:0]             ExpAddr,
    input  logic [DATA_W-1:0]             ExpData,
    input  logic                          ActValid,
    input  logic [ADDR_W-1:0]             ActAddr,
    input  logic [DATA_W-1:0]             ActData,
    input  logic                          Finish,
    output logic                          Mismatch,
    output logic [ADDR_W-1:0]             MisAddr,
    output logic [DATA_W-1:0]             MisExp,
    output logic [DATA_W-1:0]             MisAct,
    output logic [commit_pkg::CNT_W-1:0]  MatchCount,
    output logic [commit_pkg::CNT_W-1:0]  MismatchCount,
    output logic                          Timeout,
    output logic                          Overflow,
    output logic                          Done,
    output logic                          Pass
);
    import commit_pkg::*;
    localparam int EW = ADDR_W + DATA_W;
    localparam int LW = $clog2(MAX_LAG + 1);
    chk_state_t state;
    logic [EW-1:0] expHead, actHead, pendExp, pendAct;
    logic [LW-1:0] lag;
    logic expFull, expEmpty, actFull, actEmpty, pendValid;
    logic live, expIn, actIn, pop, oneSided;
    assign live = state != DONE;
    assign expIn = live && ExpValid && !(IGNORE_ZERO != 0 && ExpAddr == '0);
    assign actIn = live && ActValid && !(IGNORE_ZERO != 0 && ActAddr == '0);
    assign pop = live && !expEmpty && !actEmpty;
    assign oneSided = expEmpty != actEmpty;
    commit_fifo #(.DEPTH(DEPTH), .W(EW)) expFifo (
        .Clock(Clock), .Reset(Reset), .Push(expIn && (!expFull || pop)), .Pop(pop),
        .PushData({ExpAddr, ExpData}), .Full(expFull), .Empty(expEmpty), .Head(expHead)
    );
    commit_fifo #(.DEPTH(DEPTH), .W(EW)) actFifo (
        .Clock(Clock), .Reset(Reset), .Push(actIn && (!actFull || pop)), .Pop(pop),
        .PushData({ActAddr, ActData}), .Full(actFull), .Empty(actEmpty), .Head(actHead)
    );
    // popped heads are held one cycle and judged on the next edge
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= RUN;
            pendValid <= 1'b0;
            pendExp <= '0;
            pendAct <= '0;
            Mismatch <= 1'b0;
            MisAddr <= '0;
            MisExp <= '0;
            MisAct <= '0;
            MatchCount <= '0;
            MismatchCount <= '0;
            Timeout <= 1'b0;
            Overflow <= 1'b0;
            lag <= '0;
        end else begin
            pendValid <= pop;
            pendExp <= expHead;
            pendAct <= actHead;
            Mismatch <= pendValid && pendExp != pendAct;
            if (pendValid && pendExp == pendAct && MatchCount != '1) MatchCount <= MatchCount + 1'b1;
            if (pendValid && pendExp != pendAct) begin
                MisAddr <= pendExp[EW-1:DATA_W];
                MisExp <= pendExp[DATA_W-1:0];
                MisAct <= pendAct[DATA_W-1:0];
                if (MismatchCount != '1) MismatchCount <= MismatchCount + 1'b1;
            end
            if ((expIn && expFull && !pop) || (actIn && actFull && !pop)) Overflow <= 1'b1;
            if (live) begin
                lag <= !oneSided ? '0 : (lag == LW'(MAX_LAG)) ? lag : lag + 1'b1;
                if (oneSided && lag >= LW'(MAX_LAG - 1)) Timeout <= 1'b1;
            end
            if (state == RUN && Finish) state <= DRAIN;
            else if (state == DRAIN && ((expEmpty && actEmpty && !pendValid) || Timeout)) state <= DONE;
        end
    end
    assign Done = state == DONE;
    assign Pass = Done && !Timeout && !Overflow && MismatchCount == '0;
endmodule

// File: tb/tb_commit_checker.sv
// tb_commit_checker: random and directed stimulus against a queue-based scoreboard model
module tb_commit_checker;
    import commit_pkg::*;
    localparam int DEPTH = 8;
    localparam int MAX_LAG = 64;
    logic Clock = 0, Reset = 0, ExpValid = 0, ActValid = 0, Finish = 0;
    logic [4:0] ExpAddr = 0, ActAddr = 0;
    logic [31:0] ExpData = 0, ActData = 0;
    logic Mismatch, Timeout, Overflow, Done, Pass;
    logic [4:0] MisAddr;
    logic [31:0] MisExp, MisAct;
    logic [15:0] MatchCount, MismatchCount;
    int tests = 0, fails = 0;
    commit_t eq[$], aq[$], pe, pa;
    bit pv, mMis, mTo, mOvf;
    int lag, mState, mc, mmc;
    logic [4:0] mAddr;
    logic [31:0] mExp, mAct;

    always #5 Clock = ~Clock;

    commit_checker dut (
        .Clock(Clock), .Reset(Reset),
        .ExpValid(ExpValid), .ExpAddr(ExpAddr), .ExpData(ExpData),
        .ActValid(ActValid), .ActAddr(ActAddr), .ActData(ActData),
        .Finish(Finish), .Mismatch(Mismatch), .MisAddr(MisAddr), .MisExp(MisExp), .MisAct(MisAct),
        .MatchCount(MatchCount), .MismatchCount(MismatchCount),
        .Timeout(Timeout), .Overflow(Overflow), .Done(Done), .Pass(Pass)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        eq.delete();
        aq.delete();
        pv = 0; mMis = 0; mTo = 0; mOvf = 0;
        lag = 0; mState = 0; mc = 0; mmc = 0;
        mAddr = 0; mExp = 0; mAct = 0;
    endtask

    // one clock edge of the scoreboard rules, applied to the inputs present at that edge
    task automatic modelStep();
        bit done = mState == 2;
        bit eE = eq.size() == 0;
        bit aE = aq.size() == 0;
        bit pop = !done && !eE && !aE;
        bit toPre = mTo;
        bit pvPre = pv;
        mMis = 0;
        if (pv) begin
            if (pe == pa) mc = (mc == 65535) ? mc : mc + 1;
            else begin
                mmc = (mmc == 65535) ? mmc : mmc + 1;
                mMis = 1; mAddr = pe.addr; mExp = pe.data; mAct = pa.data;
            end
        end
        pv = pop;
        if (pop) begin
            pe = eq.pop_front();
            pa = aq.pop_front();
        end
        if (!done) begin
            if (eE != aE) begin
                if (lag < MAX_LAG) lag++;
                if (lag == MAX_LAG) mTo = 1;
            end else lag = 0;
            if (ExpValid && ExpAddr != 0) begin
                if (eq.size() < DEPTH) eq.push_back('{ExpAddr, ExpData}); else mOvf = 1;
            end
            if (ActValid && ActAddr != 0) begin
                if (aq.size() < DEPTH) aq.push_back('{ActAddr, ActData}); else mOvf = 1;
            end
            if (mState == 0 && Finish) mState = 1;
            else if (mState == 1 && ((eE && aE && !pvPre) || toPre)) mState = 2;
        end
    endtask

    task automatic cycle(input bit rst, input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                         input bit av, input logic [4:0] aa, input logic [31:0] ad, input bit fin);
        bit mPass;
        Reset = rst; ExpValid = ev; ExpAddr = ea; ExpData = ed;
        ActValid = av; ActAddr = aa; ActData = ad; Finish = fin;
        @(posedge Clock);
        if (rst) modelReset(); else modelStep();
        #1;
        mPass = mState == 2 && !mTo && !mOvf && mmc == 0;
        check("flags", {Mismatch, Timeout, Overflow, Done, Pass}, {mMis, mTo, mOvf, mState == 2, mPass});
        check("counts", {MatchCount, MismatchCount}, {16'(mc), 16'(mmc)});
        check("misaddr", MisAddr, mAddr);
        check("misdata", {MisExp, MisAct}, {mExp, mAct});
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic finishWait();
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20 && !Done; i++) idle(1);
        check("drain_done", Done, 1);
    endtask

    initial begin
        int n;
        logic [31:0] d [8];
        modelReset();
        rst();
        rst();
        check("rst_state", {Mismatch, Timeout, Overflow, Done, Pass, MatchCount, MismatchCount}, 0);

        cycle(0, 1, 3, 32'h5, 1, 3, 32'h5, 0);
        cycle(0, 1, 4, 32'hFFFF_FFFB, 1, 4, 32'hFFFF_FFFB, 0);
        idle(3);
        finishWait();
        check("eq_counts", {MatchCount, MismatchCount}, {16'd2, 16'd0});
        check("eq_pass", Pass, 1);

        rst();
        cycle(0, 1, 7, 32'h12, 1, 7, 32'h13, 0);
        idle(1);
        check("mis_early", Mismatch, 0);
        idle(1);
        check("mis_pulse", {Mismatch, MisAddr, MisExp, MisAct}, {1'b1, 5'd7, 32'h12, 32'h13});
        idle(1);
        check("mis_one_cycle", Mismatch, 0);
        finishWait();
        check("mis_pass", Pass, 0);

        rst();
        for (int i = 0; i < 8; i++) begin
            d[i] = $urandom;
            cycle(0, 0, 0, 0, 1, 5'(i + 1), d[i], 0);
        end
        for (int i = 0; i < 8; i++) cycle(0, 1, 5'(i + 1), d[i], 0, 0, 0, 0);
        idle(3);
        check("skew_no_ovf", Overflow, 0);
        check("skew_matches", MatchCount, 8);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 5'(i + 9), $urandom, 0);
        check("full_no_ovf", Overflow, 0);
        cycle(0, 0, 0, 0, 1, 5'd20, $urandom, 0);
        check("full_ovf", Overflow, 1);

        rst();
        cycle(0, 1, 9, 32'hABCD, 0, 0, 0, 0);
        n = 0;
        while (!Timeout && n < 100) begin
            idle(1);
            n++;
        end
        check("lag_cycles", n, 64);
        finishWait();
        check("lag_pass", Pass, 0);

        rst();
        cycle(0, 1, 0, 32'h1, 0, 0, 0, 0);
        idle(80);
        check("zero_filter", {Timeout, MatchCount}, 0);

        rst();
        cycle(0, 1, 5, 32'h1, 0, 0, 0, 0);
        cycle(0, 1, 6, 32'h2, 0, 0, 0, 0);
        cycle(0, 1, 7, 32'h3, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 5, 32'h9, 0);
        idle(1);
        rst();
        check("rst_mid", {Mismatch, Timeout, Overflow, Done, MatchCount, MismatchCount}, 0);
        cycle(0, 1, 6, 32'h2, 1, 6, 32'h2, 0);
        idle(2);
        check("rst_empty", {MatchCount, MismatchCount, Mismatch}, {16'd1, 16'd0, 1'b0});

        for (int r = 0; r < 6; r++) begin
            int pE = $urandom_range(20, 90);
            int pA = $urandom_range(20, 90);
            rst();
            for (int c = 0; c < 250; c++)
                cycle(0, $urandom_range(0, 99) < pE, 5'($urandom_range(0, 3)), 32'($urandom_range(0, 1)),
                      $urandom_range(0, 99) < pA, 5'($urandom_range(0, 3)), 32'($urandom_range(0, 1)),
                      c > 150 && $urandom_range(0, 99) < 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
